// File: rtl/rv32_trace_sequencer.sv
// rv32_trace_sequencer: steps the rv32 core one instruction at a time and
// captures each step's architectural signals into a first-word-fall-through
// trace FIFO. The FIFO drains to the witness writer over valid/ready.
// Optional feature macro: TRACE_CHECK_EN enables a sticky next-PC checker.
// When the macro is undefined, chk_err is tied to 0.
module rv32_trace_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [CNT_W-1:0] step_limit,
  output logic             core_step_en,
  input  logic [31:0]      core_pc,
  input  logic [31:0]      core_pc_next,
  input  logic [31:0]      core_rs1,
  input  logic [31:0]      core_rs2,
  input  logic [31:0]      core_imm,
  input  logic             core_is_beq,
  input  logic             core_is_bne,
  output logic             tr_valid,
  input  logic             tr_ready,
  output logic [31:0]      tr_pc,
  output logic [31:0]      tr_pc_next,
  output logic [31:0]      tr_rs1,
  output logic [31:0]      tr_rs2,
  output logic [31:0]      tr_imm,
  output logic [2:0]       tr_flags,
  output logic [CNT_W-1:0] tr_idx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_count,
  output logic             chk_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      imm;
    logic [2:0]       flags;
    logic [CNT_W-1:0] idx;
  } rec_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  rec_t             mem [DEPTH];
  rec_t             head_rec;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             fifo_full, fifo_empty;
  logic             push, pop, taken, launch;

  // Saturating step counter increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Full when pointers differ only in the wrap bit; empty when identical.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign taken   = (core_is_beq && (core_rs1 == core_rs2)) ||
                   (core_is_bne && (core_rs1 != core_rs2));
  assign cnt_inc = sat_inc(cnt_q);
  assign push    = core_step_en;
  assign pop     = !fifo_empty && tr_ready;

  // Next-state decode and core step gating; stepping only happens in RUN.
  always_comb begin
    state_d      = state_q;
    core_step_en = 1'b0;
    launch       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = (step_limit == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Full flag is registered, so a same-cycle pop cannot unblock a push.
        core_step_en = !fifo_full;
        if (halt_req || (!fifo_full && (cnt_inc == limit_q)))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, FIFO pointers, latched limit and step counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      limit_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (launch) begin
        limit_q <= step_limit;
        cnt_q   <= '0;
      end else if (push) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  // Trace storage; contents need no reset because outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q[AW-1:0]] <= '{pc:      core_pc,
                                 pc_next: core_pc_next,
                                 rs1:     core_rs1,
                                 rs2:     core_rs2,
                                 imm:     core_imm,
                                 flags:   {taken, core_is_bne, core_is_beq},
                                 idx:     cnt_q};
  end

  // Head of FIFO presented directly; all fields read zero while empty.
  always_comb begin
    head_rec = '0;
    if (!fifo_empty)
      head_rec = mem[rd_ptr_q[AW-1:0]];
  end

  assign tr_valid   = !fifo_empty;
  assign tr_pc      = head_rec.pc;
  assign tr_pc_next = head_rec.pc_next;
  assign tr_rs1     = head_rec.rs1;
  assign tr_rs2     = head_rec.rs2;
  assign tr_imm     = head_rec.imm;
  assign tr_flags   = head_rec.flags;
  assign tr_idx     = head_rec.idx;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign step_count = cnt_q;

`ifdef TRACE_CHECK_EN
  logic [31:0] exp_next;
  logic        chk_q;

  assign exp_next = taken ? (core_pc + core_imm) : (core_pc + 32'd4);

  // Sticky flag: any captured step whose next PC disagrees with the decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      chk_q <= 1'b0;
    else if (push && (core_pc_next != exp_next))
      chk_q <= 1'b1;
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_trace_sequencer.sv
// Self-checking bench for rv32_trace_sequencer: directed scenarios with
// randomized core observables and consumer backpressure, compared each cycle
// against a transaction-level model (record queue, step counter, run phase).
module tb_rv32_trace_sequencer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             halt_req;
  logic [CNT_W-1:0] step_limit;
  logic             core_step_en;
  logic [31:0]      core_pc, core_pc_next, core_rs1, core_rs2, core_imm;
  logic             core_is_beq, core_is_bne;
  logic             tr_valid;
  logic             tr_ready;
  logic [31:0]      tr_pc, tr_pc_next, tr_rs1, tr_rs2, tr_imm;
  logic [2:0]       tr_flags;
  logic [CNT_W-1:0] tr_idx;
  logic             busy, done;
  logic [CNT_W-1:0] step_count;
  logic             chk_err;

  rv32_trace_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .step_limit(step_limit), .core_step_en(core_step_en),
    .core_pc(core_pc), .core_pc_next(core_pc_next), .core_rs1(core_rs1),
    .core_rs2(core_rs2), .core_imm(core_imm), .core_is_beq(core_is_beq),
    .core_is_bne(core_is_bne), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_pc(tr_pc), .tr_pc_next(tr_pc_next), .tr_rs1(tr_rs1), .tr_rs2(tr_rs2),
    .tr_imm(tr_imm), .tr_flags(tr_flags), .tr_idx(tr_idx), .busy(busy),
    .done(done), .step_count(step_count), .chk_err(chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, pcn, rs1, rs2, imm;
    logic        beq, bne;
  } core_t;

  typedef struct {
    logic [31:0]      pc, pcn, rs1, rs2, imm;
    logic [2:0]       flags;
    logic [CNT_W-1:0] idx;
  } rec_t;

  rec_t  mq[$];
  core_t dirq[$];
  int    m_phase, m_cnt, m_lim;
  bit    m_chk;
  int    ready_mode;
  int    n_tests, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic core_t rand_core();
    core_t c;
    int    sel;
    logic  tk;
    c.pc  = $urandom & 32'hFFFF_FFFC;
    c.rs1 = $urandom;
    c.rs2 = ($urandom_range(0, 1) == 1) ? c.rs1 : 32'($urandom);
    sel   = $urandom_range(0, 2);
    c.beq = (sel == 1);
    c.bne = (sel == 2);
    c.imm = $urandom & 32'hFFFF_FFFE;
    tk    = (c.beq && c.rs1 == c.rs2) || (c.bne && c.rs1 != c.rs2);
    c.pcn = tk ? c.pc + c.imm : c.pc + 32'd4;
    return c;
  endfunction

  task automatic drive_core(input core_t c);
    core_pc = c.pc; core_pc_next = c.pcn; core_rs1 = c.rs1; core_rs2 = c.rs2;
    core_imm = c.imm; core_is_beq = c.beq; core_is_bne = c.bne;
  endtask

  task automatic next_core();
    if (dirq.size() > 0) drive_core(dirq.pop_front());
    else drive_core(rand_core());
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = PH_IDLE; m_cnt = 0; m_lim = 0; m_chk = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, then the edge.
  task automatic cycle();
    bit   exp_en, m_push, m_pop, was_empty, tk;
    rec_t r;
    rec_t head;
    @(negedge clk);
    exp_en = (m_phase == PH_RUN) && (mq.size() < DEPTH);
    head   = '{default: '0};
    if (mq.size() > 0) head = mq[0];
    chk("core_step_en", core_step_en, exp_en);
    chk("tr_valid", tr_valid, mq.size() > 0);
    chk("tr_pc", tr_pc, head.pc);
    chk("tr_pc_next", tr_pc_next, head.pcn);
    chk("tr_rs1", tr_rs1, head.rs1);
    chk("tr_rs2", tr_rs2, head.rs2);
    chk("tr_imm", tr_imm, head.imm);
    chk("tr_flags", tr_flags, head.flags);
    chk("tr_idx", tr_idx, head.idx);
    chk("busy", busy, m_phase == PH_RUN || m_phase == PH_DRAIN);
    chk("done", done, m_phase == PH_DONE);
    chk("step_count", step_count, m_cnt);
    chk("chk_err", chk_err, m_chk);

    m_push    = exp_en;
    m_pop     = (mq.size() > 0) && tr_ready;
    was_empty = (mq.size() == 0);
    if (m_pop) void'(mq.pop_front());
    if (m_push) begin
      tk      = (core_is_beq && core_rs1 == core_rs2) || (core_is_bne && core_rs1 != core_rs2);
      r.pc    = core_pc; r.pcn = core_pc_next; r.rs1 = core_rs1; r.rs2 = core_rs2;
      r.imm   = core_imm; r.flags = {tk, core_is_bne, core_is_beq}; r.idx = CNT_W'(m_cnt);
      mq.push_back(r);
`ifdef TRACE_CHECK_EN
      if (core_pc_next != (tk ? core_pc + core_imm : core_pc + 32'd4)) m_chk = 1;
`endif
    end
    if (reset_n) begin
      case (m_phase)
        PH_IDLE, PH_DONE:
          if (start) begin
            m_lim = int'(step_limit); m_cnt = 0;
            m_phase = (m_lim == 0) ? PH_DONE : PH_RUN;
          end
        PH_RUN: begin
          if (m_push) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_cnt == m_lim || halt_req) m_phase = PH_DRAIN;
          end else if (halt_req) m_phase = PH_DRAIN;
        end
        PH_DRAIN: if (was_empty) m_phase = PH_DONE;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    if (m_push) next_core();
    if (ready_mode == 2) tr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin cycle(); k++; end
    chk(tag, done, 1'b1);
  endtask

  task automatic launch(input int lim);
    step_limit = CNT_W'(lim);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    core_t c0, c1, c2;
    int    k;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; start = 1'b0; halt_req = 1'b0; step_limit = '0;
    tr_ready = 1'b1; ready_mode = 1;
    model_reset();
    drive_core(rand_core());

    // Reset state.
    cycle(); cycle();
    reset_n = 1'b1;
    cycle();

    // Directed three-step run from core reset state.
    c0 = '{pc: 32'd8,  pcn: 32'd16, rs1: 32'd5, rs2: 32'd6, imm: 32'd8,  beq: 1'b0, bne: 1'b1};
    c1 = '{pc: 32'd16, pcn: 32'd20, rs1: 32'd5, rs2: 32'd5, imm: 32'd4,  beq: 1'b1, bne: 1'b0};
    c2 = '{pc: 32'd20, pcn: 32'd24, rs1: 32'd5, rs2: 32'd6, imm: 32'd12, beq: 1'b0, bne: 1'b0};
    drive_core(c0); dirq.push_back(c1); dirq.push_back(c2);
    launch(3);
    run_until_done("A_done", 40);
    chk("A_step_count", step_count, 3);

    // Backpressure: FIFO fills to DEPTH then stepping stalls.
    ready_mode = 0; tr_ready = 1'b0;
    launch(20);
    for (int i = 0; i < 14; i++) cycle();
    chk("B_stalled_en", core_step_en, 1'b0);
    chk("B_full_idx", tr_idx, 0);
    ready_mode = 1; tr_ready = 1'b1;
    run_until_done("B_done", 200);
    chk("B_step_count", step_count, 20);

    // Halt during step 5.
    ready_mode = 2;
    launch(100);
    k = 0;
    while (!(m_phase == PH_RUN && m_cnt == 5 && mq.size() < DEPTH) && k < 200) begin cycle(); k++; end
    chk("C_reach_step5", step_count, 5);
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    chk("C_draining", busy, 1'b1);
    run_until_done("C_done", 200);
    chk("C_step_count", step_count, 6);

    // Zero-length run.
    launch(0);
    chk("D_done_next", done, 1'b1);
    cycle(); cycle();

    // Asynchronous reset mid-run with 4 records queued.
    ready_mode = 0; tr_ready = 1'b0;
    launch(50);
    k = 0;
    while (mq.size() != 4 && k < 50) begin cycle(); k++; end
    chk("E_queued", tr_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("E_rst_valid", tr_valid, 1'b0);
    chk("E_rst_count", step_count, 0);
    chk("E_rst_busy", busy, 1'b0);
    chk("E_rst_en", core_step_en, 1'b0);
    model_reset();
    cycle();
    reset_n = 1'b1;
    cycle();

    // Long randomized run with random backpressure.
    ready_mode = 2;
    launch(60);
    run_until_done("F_done", 2000);
    chk("F_step_count", step_count, 60);

    // Next-PC checker: bne taken but pc_next claims fall-through.
    ready_mode = 1; tr_ready = 1'b1;
    dirq.delete();
    drive_core('{pc: 32'd8, pcn: 32'd12, rs1: 32'd5, rs2: 32'd6, imm: 32'd8, beq: 1'b0, bne: 1'b1});
    launch(2);
    run_until_done("G_done", 40);
    for (int i = 0; i < 3; i++) cycle();
`ifdef TRACE_CHECK_EN
    chk("G_chk_sticky", chk_err, 1'b1);
`else
    chk("G_chk_tied", chk_err, 1'b0);
`endif
    reset_n = 1'b0;
    #1;
    chk("G_chk_cleared", chk_err, 1'b0);
    model_reset();
    cycle();
    reset_n = 1'b1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
